mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// - Memory-access stage; sits directly after execute. Consumes execute's alu_out, r2_out and info_ff.
// - Runs loads/stores over a req/ack data-memory bus and formats load data (size/sign).
// - Registers mem_out/mem_info; execute forwards from these and writeback consumes them.
// - Holds the pipeline via req.stall_req while a bus access is outstanding.
// PARAMETERS
// - none (XLEN fixed at 32)
// PORTS
// clk         in   1    clock; all flops on posedge
// rst         in   1    asynchronous, active-low reset
// req         out  PipeRequest  stall_req = memory access pending; flush_req always 4'b0000
// pipe        in   PipeControl  global stall/flush for this stage
// info        in   DecodeInfo   instruction from execute (info_ff there); uses enable, mem_read, mem_write, funct3
// alu_out     in   32   effective address, or non-memory result
// r2_out      in   32   store data
// dmem_req    out  1    bus request; held until dmem_ack
// dmem_we     out  1    1 = store
// dmem_addr   out  32   word-aligned address {alu_out[31:2],2'b00}
// dmem_be     out  4    byte enables
// dmem_wdata  out  32   store data, replicated across lanes
// dmem_ack    in   1    transfer complete; dmem_rdata valid this cycle
// dmem_rdata  in   32   load word
// misalign    out  1    misaligned access (MEM_MISALIGN_TRAP_EN only, else 0)
// mem_out     out  32   registered stage result
// mem_info    out  DecodeInfo   registered info for forwarding/writeback
// BEHAVIOUR
// - Reset (rst=0, async): mem_out=0, mem_info=0, state=IDLE, ld_buf=0, dmem_req=0.
// - mem_op = info.enable & (info.mem_read | info.mem_write).
// - FSM states:
//   - IDLE:
//     - mem_op & !pipe.flush: dmem_req=1 combinationally.
//     - dmem_ack same cycle -> done (zero-wait bus); else -> BUSY.
//   - BUSY: dmem_req=1; addr/be/wdata held stable.
//     - dmem_ack: capture data; -> IDLE if !pipe.stall, else -> HOLD.
//     - pipe.flush seen while BUSY -> DRAIN.
//   - HOLD: access done, another stage stalls. Load data held in ld_buf; no new request; -> IDLE when !pipe.stall.
//   - DRAIN: flushed op still on bus; keep dmem_req until dmem_ack, drop data, -> IDLE.
//     - A new mem_op waits here with stall_req=1.
// - req.stall_req = mem_op & !(dmem_ack & state∈{IDLE,BUSY}) & state!=HOLD.
//   - Also 1 in DRAIN when mem_op.
// - Byte lanes by funct3[1:0]:
//   - 00 byte: be=1<<a[1:0], wdata={4{r2[7:0]}}
//   - 01 half: be=a[1]?1100:0011, wdata={2{r2[15:0]}}
//   - 10 word: be=1111
// - Load format: select lane by a[1:0].
//   - funct3 0 LB / 1 LH: sign-extend.
//   - funct3 4 LBU / 5 LHU: zero-extend.
//   - funct3 2 LW: full word.
// - Registers update only when !pipe.stall (flush wins over stall; flush -> both 0):
//   - mem_info <= info.
//   - mem_out <= !info.enable ? 0 : info.mem_read ? fmt_load : info.mem_write ? 0 : alu_out.
// - Latency: non-memory op 1 cycle. Load/store 1 + bus wait cycles.
// - Stores never write mem_out; mem_info passes through unchanged.
// CONFIGURATION
// - MEM_MISALIGN_TRAP_EN defined:
//   - half with a[0]=1, or word with a[1:0]!=0 -> no bus request, stall_req=0.
//   - misalign=1 for that cycle; mem_info.enable registered as 0 (instruction squashed).
// - Not defined:
//   - misalign tied 0; low address bits ignored for lane select above the access size (half uses a[1], word uses none).
//   - Access always issued.
// TESTING
// 1. Reset low mid-BUSY -> dmem_req=0, mem_out=0, mem_info=0 immediately; IDLE after release.
// 2. LW, alu_out=0x100, ack same cycle, rdata=0xDEADBEEF -> stall_req never 1; next cycle mem_out=0xDEADBEEF.
// 3. LB, alu_out=0x103, rdata=0x80AABBCC, ack after 3 cycles -> stall_req=1 for 3 cycles; be=1000; mem_out=0xFFFFFF80.
//    LBU same case -> mem_out=0x00000080.
// 4. SH, alu_out=0x202, r2_out=0x1234ABCD -> dmem_we=1, addr=0x200, be=1100, wdata=0xABCDABCD; mem_out=0.
// 5. ADD passing through (alu_out=7) while pipe.stall=1 for 2 cycles -> mem_out/mem_info hold, then mem_out=7.
//    Also: ack while pipe.stall=1 -> HOLD, ld_buf retained.
// 6. pipe.flush during BUSY -> DRAIN; late ack data discarded; mem_info=0.
//    With MEM_MISALIGN_TRAP_EN: LW at 0x101 -> dmem_req=0, misalign=1, mem_info.enable=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: load/store stage driving a req/ack data bus, formats load data.
// Build option: define MEM_MISALIGN_TRAP_EN to squash misaligned half/word ops.

package mem_pkg;
    typedef struct packed {
        logic       stall_req;
        logic [3:0] flush_req;
    } PipeRequest;

    typedef struct packed {
        logic stall;
        logic flush;
    } PipeControl;

    typedef struct packed {
        logic       enable;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } DecodeInfo;
endpackage

module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output PipeRequest  req,
    input  PipeControl  pipe,
    input  DecodeInfo   info,
    input  logic [31:0] alu_out,
    input  logic [31:0] r2_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        misalign,
    output logic [31:0] mem_out,
    output DecodeInfo   mem_info
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] ld_buf_q;
    logic [31:0] mem_out_q;
    DecodeInfo   mem_info_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;

    logic        mem_op;
    logic        mis_c;
    logic        start;
    logic        req_c;
    logic        stall_c;
    logic        upd;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] raw;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] fmt_c;
    logic [31:0] out_c;
    DecodeInfo   info_c;

    assign mem_op = info.enable & (info.mem_read | info.mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_c = mem_op &
                   (((info.funct3[1:0] == 2'b01) & alu_out[0]) |
                    (info.funct3[1] & (alu_out[1:0] != 2'b00)));
`else
    assign mis_c = 1'b0;
`endif

    assign misalign = mis_c;
    assign start    = mem_op & ~pipe.flush & ~mis_c;

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = r2_out;
        unique case (info.funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << alu_out[1:0];
                wdata_c = {4{r2_out[7:0]}};
            end
            2'b01: begin
                be_c    = alu_out[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{r2_out[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = r2_out;
            end
        endcase
    end

    // Load lane select and sign/zero extension; HOLD replays the buffered word
    always_comb begin
        raw    = (state_q == HOLD) ? ld_buf_q : dmem_rdata;
        byte_c = raw[{alu_out[1:0], 3'b000} +: 8];
        half_c = alu_out[1] ? raw[31:16] : raw[15:0];
        unique case (info.funct3)
            3'd0:    fmt_c = {{24{byte_c[7]}}, byte_c};
            3'd1:    fmt_c = {{16{half_c[15]}}, half_c};
            3'd4:    fmt_c = {24'b0, byte_c};
            3'd5:    fmt_c = {16'b0, half_c};
            default: fmt_c = raw;
        endcase
    end

    // Stage result and forwarded info (misaligned ops are squashed)
    always_comb begin
        info_c        = info;
        info_c.enable = info.enable & ~mis_c;
        if (!info.enable | mis_c)  out_c = '0;
        else if (info.mem_read)    out_c = fmt_c;
        else if (info.mem_write)   out_c = '0;
        else                       out_c = alu_out;
    end

    // Bus access FSM: next state and request
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_c = start;
                if (start)
                    state_d = dmem_ack ? (pipe.stall ? HOLD : IDLE) : BUSY;
            end
            BUSY: begin
                req_c = 1'b1;
                if (dmem_ack)
                    state_d = (pipe.stall & ~pipe.flush) ? HOLD : IDLE;
                else if (pipe.flush)
                    state_d = DRAIN;
            end
            HOLD: begin
                if (pipe.flush | ~pipe.stall)
                    state_d = IDLE;
            end
            DRAIN: begin
                req_c = 1'b1;
                if (dmem_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_c = mem_op & ~mis_c & (state_q != HOLD) &
                     ~(dmem_ack & ((state_q == IDLE) | (state_q == BUSY)));
    assign upd     = ~pipe.stall & ~stall_c;

    // State, load buffer and the bus request captured at issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ld_buf_q    <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (req_c & dmem_ack & (state_q != DRAIN))
                ld_buf_q <= dmem_rdata;
            if ((state_q == IDLE) & start) begin
                bus_we_q    <= info.mem_write;
                bus_addr_q  <= {alu_out[31:2], 2'b00};
                bus_be_q    <= be_c;
                bus_wdata_q <= wdata_c;
            end
        end
    end

    // Stage output registers; flush clears, stall holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_out_q  <= '0;
            mem_info_q <= '0;
        end else if (pipe.flush) begin
            mem_out_q  <= '0;
            mem_info_q <= '0;
        end else if (upd) begin
            mem_out_q  <= out_c;
            mem_info_q <= info_c;
        end
    end

    assign dmem_req   = req_c & rst;
    assign dmem_we    = (state_q == IDLE) ? info.mem_write : bus_we_q;
    assign dmem_addr  = (state_q == IDLE) ? {alu_out[31:2], 2'b00} : bus_addr_q;
    assign dmem_be    = (state_q == IDLE) ? be_c : bus_be_q;
    assign dmem_wdata = (state_q == IDLE) ? wdata_c : bus_wdata_q;
    assign req        = {stall_c, 4'b0000};
    assign mem_out    = mem_out_q;
    assign mem_info   = mem_info_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, corner sequences and randomized run
// against a byte-addressed memory model for mem_stage.

module tb_mem_stage;
    import mem_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    PipeRequest  req;
    PipeControl  pipe;
    DecodeInfo   info;
    logic [31:0] alu_out, r2_out;
    logic        dmem_req, dmem_we, dmem_ack, misalign;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, mem_out;
    logic [3:0]  dmem_be;
    DecodeInfo   mem_info;
    logic        ext_stall, flush;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_b [256];
    logic [31:0] slv   [64];

    assign pipe = {req.stall_req | ext_stall, flush};

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .req(req), .pipe(pipe), .info(info),
        .alu_out(alu_out), .r2_out(r2_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .misalign(misalign), .mem_out(mem_out), .mem_info(mem_info)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] r2;
        logic [31:0] rd;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_out;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic DecodeInfo mk(input logic en, input logic [4:0] rd,
                                     input logic rw, input logic mr,
                                     input logic mw, input logic [2:0] f3);
        DecodeInfo d;
        d.enable    = en;
        d.rd        = rd;
        d.reg_write = rw;
        d.mem_read  = mr;
        d.mem_write = mw;
        d.funct3    = f3;
        return d;
    endfunction

    // Architectural result of one instruction over a byte memory
    task automatic model(input DecodeInfo d, input logic [31:0] a,
                         input logic [31:0] r, output logic [31:0] v,
                         output bit mis);
        int sz, base;
        v   = '0;
        mis = 1'b0;
        if (!d.enable) return;
        if (!(d.mem_read || d.mem_write)) begin
            v = a;
            return;
        end
        sz   = (d.funct3[1:0] == 2'd0) ? 1 : (d.funct3[1:0] == 2'd1) ? 2 : 4;
        base = int'(a) - (int'(a) % sz);
        mis  = TRAP && (base != int'(a));
        if (mis) return;
        if (d.mem_write) begin
            for (int k = 0; k < sz; k++) ref_b[base + k] = r[8*k +: 8];
            return;
        end
        for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_b[base + k];
        if (!d.funct3[2] && sz < 4 && v[8*sz - 1])
            v = v | (32'hFFFF_FFFF << (8*sz));
    endtask

    task automatic run_load(input string nm, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] rd,
                            input int waits, input logic [3:0] ebe,
                            input logic [31:0] eout);
        int n;
        n          = 0;
        info       = mk(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, f3);
        alu_out    = a;
        dmem_rdata = rd;
        dmem_ack   = 1'b0;
        #2;
        chk({nm, "_be"}, {28'b0, dmem_be}, {28'b0, ebe});
        for (int i = 0; i < waits; i++) begin
            if (req.stall_req) n++;
            @(posedge clk); #3;
        end
        dmem_ack = 1'b1;
        #1;
        chk({nm, "_ack_stall"}, {31'b0, req.stall_req}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk({nm, "_stall_cycles"}, n, waits);
        chk({nm, "_out"}, mem_out, eout);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] lf3 [5];
        lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        vt[0] = '{1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF};
        vt[1] = '{1'b0, 3'd0, 32'h103, 32'h0, 32'h80AABBCC, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80};
        vt[2] = '{1'b0, 3'd4, 32'h103, 32'h0, 32'h80AABBCC, 32'h100, 4'h8, 32'h0, 32'h00000080};
        vt[3] = '{1'b0, 3'd1, 32'h102, 32'h0, 32'h80AABBCC, 32'h100, 4'hC, 32'h0, 32'hFFFF80AA};
        vt[4] = '{1'b0, 3'd5, 32'h100, 32'h0, 32'h80AA8BCC, 32'h100, 4'h3, 32'h0, 32'h00008BCC};
        vt[5] = '{1'b0, 3'd0, 32'h101, 32'h0, 32'h12345678, 32'h100, 4'h2, 32'h0, 32'h00000056};
        vt[6] = '{1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 32'h200, 4'hC, 32'hABCDABCD, 32'h0};
        vt[7] = '{1'b1, 3'd0, 32'h005, 32'h000000EE, 32'h0, 32'h004, 4'h2, 32'hEEEEEEEE, 32'h0};
        vt[8] = '{1'b1, 3'd2, 32'h0FC, 32'hCAFEF00D, 32'h0, 32'h0FC, 4'hF, 32'hCAFEF00D, 32'h0};
        vt[9] = '{1'b0, 3'd1, 32'h100, 32'h0, 32'h00007FFF, 32'h100, 4'h3, 32'h0, 32'h00007FFF};

        rst = 1'b0; info = '0; alu_out = '0; r2_out = '0;
        dmem_ack = 1'b0; dmem_rdata = '0; ext_stall = 1'b0; flush = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_out", mem_out, 32'd0);
        chk("rst_mem_info", 32'(mem_info), 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // zero-wait vector table
        for (int i = 0; i < 10; i++) begin
            DecodeInfo d;
            d = vt[i].st ? mk(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, vt[i].f3)
                         : mk(1'b1, 5'(i + 1), 1'b1, 1'b1, 1'b0, vt[i].f3);
            info = d; alu_out = vt[i].a; r2_out = vt[i].r2;
            dmem_rdata = vt[i].rd; dmem_ack = 1'b1;
            #2;
            chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, 32'd1);
            chk($sformatf("v%0d_we", i), {31'b0, dmem_we}, {31'b0, vt[i].st});
            chk($sformatf("v%0d_addr", i), dmem_addr, vt[i].e_addr);
            chk($sformatf("v%0d_be", i), {28'b0, dmem_be}, {28'b0, vt[i].e_be});
            if (vt[i].st)
                chk($sformatf("v%0d_wdata", i), dmem_wdata, vt[i].e_wd);
            chk($sformatf("v%0d_stall", i), {31'b0, req.stall_req}, 32'd0);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            chk($sformatf("v%0d_out", i), mem_out, vt[i].e_out);
            chk($sformatf("v%0d_info", i), 32'(mem_info), 32'(d));
        end

        // LB / LBU with three bus wait cycles
        run_load("lb_wait", 3'd0, 32'h103, 32'h80AABBCC, 3, 4'h8, 32'hFFFFFF80);
        run_load("lbu_wait", 3'd4, 32'h103, 32'h80AABBCC, 3, 4'h8, 32'h00000080);

        // ADD held by an external stall for two cycles
        info = mk(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 3'd0);
        alu_out = 32'd7; ext_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("add_hold_out", mem_out, 32'h80);
            chk("add_hold_info", 32'(mem_info),
                32'(mk(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 3'd4)));
        end
        ext_stall = 1'b0;
        @(posedge clk); #1;
        chk("add_out", mem_out, 32'd7);
        chk("add_info", 32'(mem_info), 32'(mk(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 3'd0)));

        // ack while externally stalled: data must survive in the buffer
        info = mk(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 3'd2);
        alu_out = 32'h10; dmem_rdata = 32'h11223344; dmem_ack = 1'b1;
        ext_stall = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'hBAD0BAD0;
        #2;
        chk("hold_req", {31'b0, dmem_req}, 32'd0);
        chk("hold_stall", {31'b0, req.stall_req}, 32'd0);
        @(posedge clk); #1;
        chk("hold_out_kept", mem_out, 32'd7);
        ext_stall = 1'b0;
        @(posedge clk); #1;
        chk("hold_out", mem_out, 32'h11223344);

        // flush while BUSY, then a new load waits out the drain
        info = mk(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 3'd2);
        alu_out = 32'h40;
        @(posedge clk); #1;
        flush = 1'b1;
        #2;
        chk("busy_req", {31'b0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_info", 32'(mem_info), 32'd0);
        chk("flush_out", mem_out, 32'd0);
        info = mk(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 3'd2);
        alu_out = 32'h80;
        #2;
        chk("drain_req", {31'b0, dmem_req}, 32'd1);
        chk("drain_addr", dmem_addr, 32'h40);
        chk("drain_stall", {31'b0, req.stall_req}, 32'd1);
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'hFEEDFACE;
        #2;
        chk("drain_ack_stall", {31'b0, req.stall_req}, 32'd1);
        @(posedge clk); #1;
        chk("drain_drop", mem_out, 32'd0);
        dmem_rdata = 32'h0BADCAFE;
        #2;
        chk("after_drain_addr", dmem_addr, 32'h80);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("after_drain_out", mem_out, 32'h0BADCAFE);

        // asynchronous reset in the middle of a BUSY access
        info = mk(1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 3'd2);
        alu_out = 32'h300;
        @(posedge clk); #4;
        rst = 1'b0;
        #1;
        chk("arst_req", {31'b0, dmem_req}, 32'd0);
        chk("arst_out", mem_out, 32'd0);
        chk("arst_info", 32'(mem_info), 32'd0);
        info = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("arst_idle", {31'b0, dmem_req}, 32'd0);
        @(posedge clk); #1;

        // misaligned word load
        info = mk(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 3'd2);
        alu_out = 32'h101;
`ifdef MEM_MISALIGN_TRAP_EN
        #2;
        chk("mis_req", {31'b0, dmem_req}, 32'd0);
        chk("mis_flag", {31'b0, misalign}, 32'd1);
        chk("mis_stall", {31'b0, req.stall_req}, 32'd0);
        @(posedge clk); #1;
        chk("mis_info", 32'(mem_info), 32'(mk(1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 3'd2)));
        chk("mis_out", mem_out, 32'd0);
`else
        dmem_rdata = 32'h12345678; dmem_ack = 1'b1;
        #2;
        chk("mis_flag", {31'b0, misalign}, 32'd0);
        chk("mis_req", {31'b0, dmem_req}, 32'd1);
        chk("mis_addr", dmem_addr, 32'h100);
        chk("mis_be", {28'b0, dmem_be}, 32'hF);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("mis_out", mem_out, 32'h12345678);
`endif

        // randomized instruction stream against the memory model
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = $urandom;
            slv[i] = w;
            for (int k = 0; k < 4; k++) ref_b[4*i + k] = w[8*k +: 8];
        end
        for (int n = 0; n < 300; n++) begin
            int kind, lat, wc;
            bit acked, done, stalled, badreq, mis;
            logic [2:0] f3;
            logic [31:0] a, r, e_out;
            DecodeInfo d, e_info;
            kind = $urandom_range(0, 2);
            if (kind == 1)      f3 = lf3[$urandom_range(0, 4)];
            else if (kind == 2) f3 = 3'($urandom_range(0, 2));
            else                f3 = 3'($urandom);
            d = mk(($urandom_range(0, 7) != 0), 5'($urandom), 1'($urandom),
                   kind == 1, kind == 2, f3);
            a = $urandom_range(0, 255);
            r = $urandom;
            model(d, a, r, e_out, mis);
            e_info = d;
            if (mis) e_info.enable = 1'b0;
            info = d; alu_out = a; r2_out = r;
            lat = $urandom_range(0, 3);
            wc = 0; acked = 1'b0; done = 1'b0; badreq = 1'b0;
            for (int c = 0; c < 40; c++) begin
                ext_stall = ($urandom_range(0, 3) == 0);
                #1;
                if (dmem_req) begin
                    if (acked || kind == 0 || !d.enable || mis) begin
                        badreq = 1'b1;
                    end else if (wc >= lat) begin
                        dmem_ack = 1'b1;
                        dmem_rdata = slv[dmem_addr[7:2]];
                        if (dmem_we)
                            for (int b = 0; b < 4; b++)
                                if (dmem_be[b])
                                    slv[dmem_addr[7:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
                        acked = 1'b1;
                    end else begin
                        wc++;
                    end
                end
                #1;
                stalled = pipe.stall;
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                dmem_rdata = $urandom;
                if (!stalled) begin
                    done = 1'b1;
                    break;
                end
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL rnd_timeout instr=%0d actual=stalled required=retired", n);
            end else begin
                chk($sformatf("rnd%0d_out", n), mem_out, e_out);
                chk($sformatf("rnd%0d_info", n), 32'(mem_info), 32'(e_info));
                chk($sformatf("rnd%0d_badreq", n), {31'b0, badreq}, 32'd0);
            end
        end
        ext_stall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
